// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver
//
// Receives frames of the form: start (0), DATA_WIDTH data bits LSB-first,
// optional parity, stop (1). The line is oversampled at PRESCALE clocks per
// bit. A frame starts only on a falling edge of the line, so a line held low
// (break) never starts a new frame. Each bit is the majority of three samples
// taken around mid-bit. A start bit that votes 1 is a false start, and the
// receiver returns to idle. The frame completes at the stop-bit vote, half a
// bit early, which leaves half a bit of margin to resynchronise on the next
// start edge.
//
// Optional feature (compile-time macro UART_RX_SYNC_EN):
//   defined   -> RX_IN passes through a two-flop synchroniser (reset value 1)
//                before use. All latencies measured from RX_IN grow by 2.
//   undefined -> RX_IN is used directly. Use this only when RX_IN is already
//                synchronous to CLK.
//
// Ports:
//   CLK        single clock
//   RST        asynchronous reset, active-low
//   RX_IN      serial line, idles high
//   PRESCALE   clocks per bit (8, 16 or 32), latched at the start edge
//   PAR_EN     1 = parity bit present, latched at the start edge
//   PAR_TYP    0 = even, 1 = odd, latched at the start edge
//   P_DATA     last good received word, held between good frames
//   DATA_VALID one-cycle strobe; P_DATA updates in the same cycle
//   PAR_ERR    one-cycle strobe, parity mismatch
//   STP_ERR    one-cycle strobe, stop bit voted 0
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                      state_q, state_d;
    logic                        rx_s, rx_d;
    logic [PRESCALE_WIDTH-1:0]   pre_q, edge_cnt, half;
    logic [BW-1:0]               bit_cnt;
    logic                        par_en_q, par_typ_q, par_bad_q;
    logic [DATA_WIDTH-1:0]       shift_q;
    logic                        samp_a, samp_b;
    logic                        at_s0, at_s1, at_vote, at_wrap;
    logic                        vote, start_edge;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    // Mid-bit sample points: the third vote uses the live line, so the bit
    // value is ready on the P/2+1 edge itself.
    assign half       = pre_q >> 1;
    assign at_s0      = (edge_cnt == half - ONE);
    assign at_s1      = (edge_cnt == half);
    assign at_vote    = (edge_cnt == half + ONE);
    assign at_wrap    = (edge_cnt == pre_q - ONE);
    assign vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign start_edge = rx_d & ~rx_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: assign the default first so that no path through the case leaves state_d unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_edge) state_d = START;
            START: begin
                if (at_vote && vote) state_d = IDLE;
                else if (at_wrap)    state_d = DATA;
            end
            DATA:    if (at_wrap && bit_cnt == LAST_BIT)
                         state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (at_wrap) state_d = STOP;
            STOP:    if (at_vote) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register in this design is small, so all of it, including the shift register, is reset. This makes reset abort a frame cleanly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_d       <= 1'b1;
            pre_q      <= '0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            shift_q    <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so that every register samples the values from before this edge.
            rx_d       <= rx_s;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state_q == IDLE) begin
                if (start_edge) begin
                    // The detect cycle counts as edge 0 of the start bit.
                    pre_q     <= PRESCALE;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    par_bad_q <= 1'b0;
                    edge_cnt  <= ONE;
                    bit_cnt   <= '0;
                end else begin
                    edge_cnt  <= '0;
                end
            end else begin
                edge_cnt <= at_wrap ? '0 : edge_cnt + ONE;
                if (at_s0) samp_a <= rx_s;
                if (at_s1) samp_b <= rx_s;
            end

            case (state_q)
                DATA: begin
                    if (at_vote) shift_q <= {vote, shift_q[DATA_WIDTH-1:1]};
                    if (at_wrap) bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: begin
                    // Even: expect XOR(data). Odd: expect its inverse.
                    if (at_vote) par_bad_q <= vote ^ (^shift_q) ^ par_typ_q;
                end
                STOP: begin
                    if (at_vote) begin
                        DATA_VALID <= vote & ~par_bad_q;
                        PAR_ERR    <= par_bad_q;
                        STP_ERR    <= ~vote;
                        if (vote && !par_bad_q) P_DATA <= shift_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// A behavioural serial driver plays the role of the TX side. A negedge
// monitor counts strobe cycles and records every received word.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] PRESCALE = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Strobe monitor, sampled on the falling edge.
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0;
    logic [DW-1:0] rx_q[$];
    always @(negedge CLK) begin
        if (DATA_VALID) begin
            dv_cnt++;
            dv_cyc = cyc;
            rx_q.push_back(P_DATA);
        end
        if (PAR_ERR) pe_cnt++;
        if (STP_ERR) se_cnt++;
    end

    int b_dv, b_pe, b_se, start_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dv = dv_cnt;
        b_pe = pe_cnt;
        b_se = se_cnt;
    endtask

    // Hold one bit for p clocks. In slot gslot the inverted value is driven instead.
    task automatic send_bit(input logic b, input int p, input int gslot);
        for (int i = 0; i < p; i++) begin
            RX_IN = (i == gslot) ? ~b : b;
            @(negedge CLK);
        end
    endtask

    // Frame bit index: 0 = start, 1..8 = data, 9 = parity. The stop value stays on the line.
    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit,
                              input int gidx, input int gslot);
        start_cyc = cyc + 1;
        send_bit(1'b0, p, (gidx == 0) ? gslot : -1);
        for (int i = 0; i < 8; i++) send_bit(d[i], p, (gidx == i + 1) ? gslot : -1);
        if (pen) send_bit(pbit, p, (gidx == 9) ? gslot : -1);
        send_bit(sbit, p, -1);
    endtask

    function automatic logic [7:0] rx_at(input int idx);
        return (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
    endfunction

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_pdata", P_DATA, 0);
        check("rst_dv", DATA_VALID, 0);
        check("rst_pe", PAR_ERR, 0);
        check("rst_se", STP_ERR, 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        // Good frame with even parity. The inputs change mid-frame and must be ignored.
        PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        fork
            send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, -1);
            begin
                repeat (30) @(negedge CLK);
                PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b1;
            end
        join
        PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        repeat (4) @(negedge CLK);
        check("t1_dv_cnt", dv_cnt - b_dv, 1);
        check("t1_pdata", P_DATA, 8'hA5);
        check("t1_latency", dv_cyc - start_cyc, 85 + SYNC_LAT);
        check("t1_pe_cnt", pe_cnt - b_pe, 0);
        check("t1_se_cnt", se_cnt - b_se, 0);

        // Parity bit wrong for even parity
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, -1);
        repeat (4) @(negedge CLK);
        check("t2_pe_cnt", pe_cnt - b_pe, 1);
        check("t2_dv_cnt", dv_cnt - b_dv, 0);
        check("t2_pdata_held", P_DATA, 8'hA5);

        // The same parity bit is correct for odd parity
        PAR_TYP = 1'b1;
        snap();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, -1);
        repeat (4) @(negedge CLK);
        check("t2b_dv_cnt", dv_cnt - b_dv, 1);
        check("t2b_pe_cnt", pe_cnt - b_pe, 0);

        // Stop error followed by a break: no retrigger while the line stays low
        PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, -1);
        repeat (100) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (200) @(negedge CLK);
        check("t3_se_cnt", se_cnt - b_se, 1);
        check("t3_dv_cnt", dv_cnt - b_dv, 0);
        check("t3_pe_cnt", pe_cnt - b_pe, 0);
        check("t3_pdata_held", P_DATA, 8'hA5);

        // False start: a 3-cycle low pulse
        snap();
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        check("t4_false_strobes", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);

        // 0x81 with the P/2 sample of data bit 3 inverted
        snap();
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 4, 8);
        repeat (4) @(negedge CLK);
        check("t4_dv_cnt", dv_cnt - b_dv, 1);
        check("t4_pdata", P_DATA, 8'h81);
        check("t4_latency", dv_cyc - start_cyc, 153 + SYNC_LAT);

        // Back-to-back frames, as a TX would send them at P=32
        PRESCALE = 6'd32;
        snap();
        base = rx_q.size();
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b1, -1, -1);
        repeat (4) @(negedge CLK);
        check("t5_dv_cnt", dv_cnt - b_dv, 3);
        check("t5_word0", rx_at(base), 8'h00);
        check("t5_word1", rx_at(base + 1), 8'hFF);
        check("t5_word2", rx_at(base + 2), 8'h55);
        check("t5_err_cnt", (pe_cnt - b_pe) + (se_cnt - b_se), 0);

        // Reset asserted during data bit 4 of 0x12
        PRESCALE = 6'd16;
        snap();
        send_bit(1'b0, 16, -1);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h12 >> i), 16, -1);
        RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("t6_rst_pdata", P_DATA, 0);
        check("t6_rst_dv", DATA_VALID, 0);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        repeat (300) @(negedge CLK);
        check("t6_no_strobe", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);

        snap();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, -1, -1);
        repeat (4) @(negedge CLK);
        check("t6_dv_cnt", dv_cnt - b_dv, 1);
        check("t6_pdata", P_DATA, 8'h12);
        check("t6_latency", dv_cyc - start_cyc, 153 + SYNC_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
